knight_anim_seq: RTL and testbench
==================================

KNIGHT_ANIM_SEQ -- requirements
Module: knight_anim_seq

Interface
REQ-001 SHALL have parameter SPR_W, default 50, sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 64, sprite height in pixels.
REQ-003 SHALL have parameter FRAME_DIV, default 6, frame_tick pulses per animation frame.
REQ-004 vga_clk  input  1  pixel clock; the only clock.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 frame_tick  input  1  one-cycle pulse, once per video frame at start of vblank.
REQ-007 airborne, landed, moving, facing_left  input  1 each  knight status from game logic, level-sensitive.
REQ-008 knight_x, knight_y  input  10 each  top-left screen position of the sprite box.
REQ-009 DrawX, DrawY  input  10 each  current pixel coordinate from the VGA controller.
REQ-010 rom_address  output  12  sprite-local ROM address, ly*SPR_W+lx.
REQ-011 sprite_hit  output  1  current pixel lies inside the sprite box.
REQ-012 frame_sel  output  3  frame index that selects among the per-frame sprite ROMs.
REQ-013 anim_state  output  2  state encoding: IDLE=0, WALK=1, FALL=2, LAND=3.

Function
REQ-014 State and frame_sel SHALL update only on cycles with frame_tick=1, so the displayed frame never changes mid-scan.
REQ-015 Next-state priority on frame_tick SHALL be: airborne, then landed, then moving.
- IDLE: airborne -> FALL; moving -> WALK.
- WALK: airborne -> FALL; !moving -> IDLE.
- FALL: landed && !airborne -> LAND.
- LAND: airborne -> FALL; otherwise -> IDLE after its final frame completes.
REQ-016 A state change SHALL clear frame_sel and the tick divider to 0 on the same frame_tick.
REQ-017 With no state change, the divider SHALL count frame_tick pulses 0..FRAME_DIV-1; when it wraps, frame_sel SHALL advance.
REQ-018 Frame counts SHALL be IDLE 1 (frame 0 only), WALK 4 (0..3, wraps to 0), FALL 2 (0..1, holds at 1), LAND 3 (0..2; the wrap after frame 2 -> IDLE).
REQ-019 lx = DrawX - knight_x and ly = DrawY - knight_y SHALL be computed 11-bit signed; hit = 0<=lx<SPR_W and 0<=ly<SPR_H.
REQ-020 When facing_left=1, the address SHALL use SPR_W-1-lx in place of lx (horizontal mirror).
REQ-021 rom_address and sprite_hit SHALL be registered with exactly 1 vga_clk latency from DrawX/DrawY.
REQ-022 rom_address SHALL be 0 when hit=0.
REQ-023 Sprite boxes that extend past x=639 or y=479 SHALL clip naturally with no wrap; DrawX<knight_x SHALL never hit.
REQ-024 Maximum address SPR_W*SPR_H-1 (3199) SHALL fit in 12 bits; the multiply SHALL be by constant SPR_W.

Reset
REQ-025 While reset_n=0: anim_state=IDLE, frame_sel=0, divider=0, rom_address=0, sprite_hit=0.
REQ-026 Reset SHALL take effect immediately, including mid-animation or mid-scan.
REQ-027 A frame_tick coincident with reset_n=0 SHALL be ignored.
REQ-028 The first frame_tick after release SHALL be evaluated from IDLE.

Structure
REQ-029 A shared package SHALL hold the anim_state enum, the per-state frame-count constants, and the SPR_W/SPR_H defaults.
REQ-030 One sub-module, knight_sprite_addr (coordinate offset, mirror, hit test, address register), SHALL be instantiated.
REQ-031 The state machine and divider SHALL live in the top module.

Verification
REQ-032 Reset, then moving=1 and 24 frame_ticks -> WALK; frame_sel sequence per tick block 0,1,2,3, then wraps to 0 on tick 24.
REQ-033 In WALK at frame_sel=2, airborne=1 on a tick -> FALL with frame_sel=0; after 6 more ticks frame_sel=1; it stays 1 after 30 further ticks.
REQ-034 FALL, landed=1 airborne=0 -> LAND; 18 ticks later -> IDLE with frame_sel=0; airborne=1 at LAND tick 7 -> FALL instead.
REQ-035 knight_x=100, knight_y=200, facing_left=0: DrawX=100/DrawY=200 -> next cycle hit=1, addr=0; DrawX=149/DrawY=263 -> addr=3199; DrawX=150 -> hit=0, addr=0.
REQ-036 facing_left=1, same position, DrawX=100/DrawY=201 -> addr=99; knight_x=620, DrawX=639 -> hit=1; DrawX=5 -> hit=0.
REQ-037 Assert reset_n=0 mid-WALK between clock edges -> all outputs at reset values before the next edge; frame_tick during reset produces no change.

Source files
------------

// File: rtl/knight_anim_seq_pkg.sv
// Shared types and constants for the knight sprite animation sequencer.
// Holds the animation state encoding, per-state frame counts and sprite geometry defaults.
package knight_anim_seq_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWalk = 2'd1,
      StFall = 2'd2,
      StLand = 2'd3
   } anim_state_e;

   localparam int unsigned SPR_W_DEFAULT = 50;
   localparam int unsigned SPR_H_DEFAULT = 64;

   localparam logic [2:0] IdleFrames = 3'd1;
   localparam logic [2:0] WalkFrames = 3'd4;
   localparam logic [2:0] FallFrames = 3'd2;
   localparam logic [2:0] LandFrames = 3'd3;

   function automatic logic [2:0] frame_count(input anim_state_e s);
      logic [2:0] n;
      case (s)
         StIdle:  n = IdleFrames;
         StWalk:  n = WalkFrames;
         StFall:  n = FallFrames;
         StLand:  n = LandFrames;
         default: n = IdleFrames;
      endcase
      return n;
   endfunction

   // Walk cycles; every other state saturates on its last frame. Leaving LAND after its
   // last frame is a state change handled by the sequencer, not here.
   function automatic logic [2:0] next_frame(input anim_state_e s, input logic [2:0] f);
      logic [2:0] last;
      logic [2:0] n;
      last = frame_count(s) - 3'd1;
      if (s == StWalk) begin
         n = (f >= last) ? 3'd0 : f + 3'd1;
      end else begin
         n = (f >= last) ? last : f + 3'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/knight_sprite_addr.sv
// Maps the current pixel to a sprite-local ROM address with optional horizontal mirror.
// Outputs are registered, one pixel clock behind DrawX/DrawY.
module knight_sprite_addr
   import knight_anim_seq_pkg::*;
#(
   parameter int unsigned SPR_W = SPR_W_DEFAULT,
   parameter int unsigned SPR_H = SPR_H_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        facing_left,
   input  logic [9:0]  knight_x,
   input  logic [9:0]  knight_y,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  draw_y,
   output logic [11:0] rom_address,
   output logic        sprite_hit
);

   logic signed [10:0] lx;
   logic signed [10:0] ly;
   logic               hit;
   logic [11:0]        col;
   logic [11:0]        addr_d;
   logic [11:0]        rom_address_q;
   logic               sprite_hit_q;

   // 11-bit signed offsets: a pixel left of / above the box goes negative instead of wrapping.
   assign lx = $signed({1'b0, draw_x}) - $signed({1'b0, knight_x});
   assign ly = $signed({1'b0, draw_y}) - $signed({1'b0, knight_y});

   assign hit = !lx[10] && (lx[9:0] < 10'(SPR_W)) &&
                !ly[10] && (ly[9:0] < 10'(SPR_H));

   always_comb begin
      col    = 12'(lx[9:0]);
      addr_d = '0;
      if (facing_left) begin
         col = 12'(SPR_W - 1) - 12'(lx[9:0]);
      end
      if (hit) begin
         addr_d = 12'(ly[9:0]) * 12'(SPR_W) + col;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_address_q <= '0;
         sprite_hit_q  <= 1'b0;
      end else begin
         rom_address_q <= addr_d;
         sprite_hit_q  <= hit;
      end
   end

   assign rom_address = rom_address_q;
   assign sprite_hit  = sprite_hit_q;

endmodule

// File: rtl/knight_anim_seq.sv
// Knight animation sequencer: picks the animation and frame once per video frame and
// forwards pixel coordinates to the sprite address generator.
module knight_anim_seq
   import knight_anim_seq_pkg::*;
#(
   parameter int unsigned SPR_W     = SPR_W_DEFAULT,
   parameter int unsigned SPR_H     = SPR_H_DEFAULT,
   parameter int unsigned FRAME_DIV = 6
) (
   input  logic        vga_clk,
   input  logic        reset_n,
   input  logic        frame_tick,
   input  logic        airborne,
   input  logic        landed,
   input  logic        moving,
   input  logic        facing_left,
   input  logic [9:0]  knight_x,
   input  logic [9:0]  knight_y,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [11:0] rom_address,
   output logic        sprite_hit,
   output logic [2:0]  frame_sel,
   output logic [1:0]  anim_state
);

   localparam int unsigned DivW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   anim_state_e      state_q, state_d;
   logic [2:0]       frame_q, frame_d;
   logic [DivW-1:0]  div_q, div_d;
   logic             div_wrap;

   assign div_wrap = (div_q == DivW'(FRAME_DIV - 1));

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         frame_q <= '0;
         div_q   <= '0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         div_q   <= div_d;
      end
   end

   // Everything advances only on frame_tick so the shown frame is stable for a whole scan.
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      div_d   = div_q;
      if (frame_tick) begin
         case (state_q)
            StIdle: begin
               if (airborne) begin
                  state_d = StFall;
               end else if (moving) begin
                  state_d = StWalk;
               end
            end
            StWalk: begin
               if (airborne) begin
                  state_d = StFall;
               end else if (!moving) begin
                  state_d = StIdle;
               end
            end
            StFall: begin
               if (landed && !airborne) begin
                  state_d = StLand;
               end
            end
            StLand: begin
               if (airborne) begin
                  state_d = StFall;
               end else if (div_wrap && (frame_q == frame_count(StLand) - 3'd1)) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase

         if (state_d != state_q) begin
            frame_d = '0;
            div_d   = '0;
         end else if (div_wrap) begin
            div_d   = '0;
            frame_d = next_frame(state_q, frame_q);
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   assign anim_state = state_q;
   assign frame_sel  = frame_q;

   knight_sprite_addr #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H)
   ) u_sprite_addr (
      .clk         (vga_clk),
      .reset_n     (reset_n),
      .facing_left (facing_left),
      .knight_x    (knight_x),
      .knight_y    (knight_y),
      .draw_x      (DrawX),
      .draw_y      (DrawY),
      .rom_address (rom_address),
      .sprite_hit  (sprite_hit)
   );

endmodule

// File: tb/tb_knight_anim_seq.sv
// Self-checking bench for knight_anim_seq: directed scenarios plus randomized status and
// coordinate stimulus against a behavioural model of the animation and address rules.
module tb_knight_anim_seq;

   localparam int SprW     = 50;
   localparam int SprH     = 64;
   localparam int FrameDiv = 6;

   logic        vga_clk = 1'b0;
   logic        reset_n;
   logic        frame_tick;
   logic        airborne;
   logic        landed;
   logic        moving;
   logic        facing_left;
   logic [9:0]  knight_x;
   logic [9:0]  knight_y;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic [11:0] rom_address;
   logic        sprite_hit;
   logic [2:0]  frame_sel;
   logic [1:0]  anim_state;

   int pass_cnt  = 0;
   int check_cnt = 0;

   // Model: 0 idle, 1 walk, 2 fall, 3 land; frames per animation.
   int m_state;
   int m_frame;
   int m_div;
   int nframes[4] = '{1, 4, 2, 3};

   always #5 vga_clk = ~vga_clk;

   knight_anim_seq #(
      .SPR_W     (SprW),
      .SPR_H     (SprH),
      .FRAME_DIV (FrameDiv)
   ) dut (
      .vga_clk     (vga_clk),
      .reset_n     (reset_n),
      .frame_tick  (frame_tick),
      .airborne    (airborne),
      .landed      (landed),
      .moving      (moving),
      .facing_left (facing_left),
      .knight_x    (knight_x),
      .knight_y    (knight_y),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .rom_address (rom_address),
      .sprite_hit  (sprite_hit),
      .frame_sel   (frame_sel),
      .anim_state  (anim_state)
   );

   task automatic model_reset();
      m_state = 0;
      m_frame = 0;
      m_div   = 0;
   endtask

   task automatic model_tick();
      int nxt;
      nxt = m_state;
      if (m_state == 0) begin
         if (airborne) nxt = 2;
         else if (moving) nxt = 1;
      end else if (m_state == 1) begin
         if (airborne) nxt = 2;
         else if (!moving) nxt = 0;
      end else if (m_state == 2) begin
         if (landed && !airborne) nxt = 3;
      end else begin
         if (airborne) nxt = 2;
         else if (m_frame == nframes[3] - 1 && m_div == FrameDiv - 1) nxt = 0;
      end
      if (nxt != m_state) begin
         m_state = nxt;
         m_frame = 0;
         m_div   = 0;
      end else if (m_div == FrameDiv - 1) begin
         m_div = 0;
         if (m_state == 1) m_frame = (m_frame + 1) % nframes[1];
         else if (m_frame + 1 < nframes[m_state]) m_frame = m_frame + 1;
      end else begin
         m_div = m_div + 1;
      end
   endtask

   function automatic void model_addr(input int kx, input int ky, input int dx, input int dy,
                                      input bit fl, output bit h, output int a);
      int lx;
      int ly;
      lx = dx - kx;
      ly = dy - ky;
      h  = (lx >= 0) && (lx < SprW) && (ly >= 0) && (ly < SprH);
      a  = h ? ly * SprW + (fl ? SprW - 1 - lx : lx) : 0;
   endfunction

   // Called at a negedge; returns at the next negedge after one frame_tick cycle.
   task automatic tick();
      frame_tick = 1'b1;
      @(negedge vga_clk);
      frame_tick = 1'b0;
      model_tick();
   endtask

   task automatic apply_reset();
      @(negedge vga_clk);
      reset_n     = 1'b0;
      frame_tick  = 1'b0;
      airborne    = 1'b0;
      landed      = 1'b0;
      moving      = 1'b0;
      facing_left = 1'b0;
      knight_x    = 10'd0;
      knight_y    = 10'd0;
      DrawX       = 10'd700;
      DrawY       = 10'd500;
      repeat (2) @(negedge vga_clk);
      reset_n = 1'b1;
      model_reset();
      @(negedge vga_clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      check_cnt++;
      if (anim_state !== 2'd0 || frame_sel !== 3'd0)
         $display("FAIL reset_state: state/frame %0d/%0d, want 0/0", anim_state, frame_sel);
      else pass_cnt++;
      check_cnt++;
      if (sprite_hit !== 1'b0 || rom_address !== 12'd0)
         $display("FAIL reset_addr: hit/addr %0d/%0d, want 0/0", sprite_hit, rom_address);
      else pass_cnt++;
      apply_reset();
   endtask

   task automatic test_walk();
      apply_reset();
      moving = 1'b1;
      tick();
      check_cnt++;
      if (anim_state !== 2'd1 || frame_sel !== 3'd0)
         $display("FAIL walk_entry: state/frame %0d/%0d, want 1/0", anim_state, frame_sel);
      else pass_cnt++;
      for (int i = 1; i <= 24; i++) begin
         tick();
         check_cnt++;
         if (anim_state !== 2'(m_state) || frame_sel !== 3'(m_frame))
            $display("FAIL walk_seq tick %0d: state/frame %0d/%0d, want %0d/%0d",
                     i, anim_state, frame_sel, m_state, m_frame);
         else pass_cnt++;
      end
      check_cnt++;
      if (frame_sel !== 3'd0)
         $display("FAIL walk_wrap: frame %0d, want 0", frame_sel);
      else pass_cnt++;
   endtask

   task automatic test_fall();
      apply_reset();
      moving = 1'b1;
      tick();
      for (int i = 0; i < 40 && m_frame != 2; i++) tick();
      check_cnt++;
      if (anim_state !== 2'd1 || frame_sel !== 3'd2)
         $display("FAIL fall_pre: state/frame %0d/%0d, want 1/2", anim_state, frame_sel);
      else pass_cnt++;
      airborne = 1'b1;
      tick();
      check_cnt++;
      if (anim_state !== 2'd2 || frame_sel !== 3'd0)
         $display("FAIL fall_entry: state/frame %0d/%0d, want 2/0", anim_state, frame_sel);
      else pass_cnt++;
      repeat (6) tick();
      check_cnt++;
      if (frame_sel !== 3'd1)
         $display("FAIL fall_frame1: frame %0d, want 1", frame_sel);
      else pass_cnt++;
      repeat (30) tick();
      check_cnt++;
      if (anim_state !== 2'd2 || frame_sel !== 3'd1)
         $display("FAIL fall_hold: state/frame %0d/%0d, want 2/1", anim_state, frame_sel);
      else pass_cnt++;
   endtask

   // Continues from the FALL state left by test_fall.
   task automatic test_land();
      airborne = 1'b0;
      landed   = 1'b1;
      tick();
      check_cnt++;
      if (anim_state !== 2'd3 || frame_sel !== 3'd0)
         $display("FAIL land_entry: state/frame %0d/%0d, want 3/0", anim_state, frame_sel);
      else pass_cnt++;
      landed = 1'b0;
      moving = 1'b0;
      repeat (17) tick();
      check_cnt++;
      if (anim_state !== 2'd3 || frame_sel !== 3'd2)
         $display("FAIL land_last: state/frame %0d/%0d, want 3/2", anim_state, frame_sel);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (anim_state !== 2'd0 || frame_sel !== 3'd0)
         $display("FAIL land_done: state/frame %0d/%0d, want 0/0", anim_state, frame_sel);
      else pass_cnt++;
      airborne = 1'b1;
      tick();
      airborne = 1'b0;
      landed   = 1'b1;
      tick();
      landed = 1'b0;
      repeat (6) tick();
      airborne = 1'b1;
      tick();
      check_cnt++;
      if (anim_state !== 2'd2 || frame_sel !== 3'd0)
         $display("FAIL land_abort: state/frame %0d/%0d, want 2/0", anim_state, frame_sel);
      else pass_cnt++;
      airborne = 1'b0;
   endtask

   task automatic test_addr_directed();
      int  pts[6][5] = '{
         '{100, 200, 149, 263, 0}, '{100, 200, 150, 263, 0}, '{100, 200, 100, 201, 1},
         '{620, 200, 639, 201, 1}, '{620, 200,   5, 201, 1}, '{100, 200,  99, 200, 0}};
      int  want_a[6] = '{3199, 0, 99, 50 + 30, 0, 0};
      bit  want_h[6] = '{1, 0, 1, 1, 0, 0};
      knight_x    = 10'd100;
      knight_y    = 10'd200;
      facing_left = 1'b0;
      DrawX       = 10'd0;
      DrawY       = 10'd0;
      @(negedge vga_clk);
      DrawX = 10'd100;
      DrawY = 10'd200;
      #1;
      check_cnt++;
      if (sprite_hit !== 1'b0)
         $display("FAIL addr_latency: hit %0d before edge, want 0", sprite_hit);
      else pass_cnt++;
      @(negedge vga_clk);
      check_cnt++;
      if (sprite_hit !== 1'b1 || rom_address !== 12'd0)
         $display("FAIL addr_origin: hit/addr %0d/%0d, want 1/0", sprite_hit, rom_address);
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         knight_x    = 10'(pts[i][0]);
         knight_y    = 10'(pts[i][1]);
         DrawX       = 10'(pts[i][2]);
         DrawY       = 10'(pts[i][3]);
         facing_left = pts[i][4][0];
         @(negedge vga_clk);
         check_cnt++;
         if (sprite_hit !== want_h[i] || rom_address !== 12'(want_a[i]))
            $display("FAIL addr_point %0d: hit/addr %0d/%0d, want %0d/%0d",
                     i, sprite_hit, rom_address, want_h[i], want_a[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_random_addr();
      bit h;
      int a;
      int dx;
      int dy;
      for (int i = 0; i < 200; i++) begin
         knight_x    = 10'($urandom_range(0, 639));
         knight_y    = 10'($urandom_range(0, 479));
         facing_left = 1'($urandom_range(0, 1));
         dx = int'(knight_x) + int'($urandom_range(0, 140)) - 60;
         dy = int'(knight_y) + int'($urandom_range(0, 160)) - 60;
         if (dx < 0) dx = 0;
         if (dx > 1023) dx = 1023;
         if (dy < 0) dy = 0;
         if (dy > 1023) dy = 1023;
         DrawX = 10'(dx);
         DrawY = 10'(dy);
         model_addr(int'(knight_x), int'(knight_y), dx, dy, facing_left, h, a);
         @(negedge vga_clk);
         check_cnt++;
         if (sprite_hit !== h || rom_address !== 12'(a))
            $display("FAIL addr_rand k=(%0d,%0d) d=(%0d,%0d) fl=%0d: hit/addr %0d/%0d, want %0d/%0d",
                     knight_x, knight_y, dx, dy, facing_left, sprite_hit, rom_address, h, a);
         else pass_cnt++;
      end
   endtask

   task automatic test_random_fsm();
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            airborne = ($urandom_range(0, 3) == 0);
            landed   = ($urandom_range(0, 1) == 0);
            moving   = ($urandom_range(0, 2) != 0);
         end
         tick();
         check_cnt++;
         if (anim_state !== 2'(m_state) || frame_sel !== 3'(m_frame))
            $display("FAIL fsm_rand tick %0d: state/frame %0d/%0d, want %0d/%0d",
                     i, anim_state, frame_sel, m_state, m_frame);
         else pass_cnt++;
         repeat ($urandom_range(0, 2)) @(negedge vga_clk);
      end
      airborne = 1'b0;
      landed   = 1'b0;
      moving   = 1'b0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      moving = 1'b1;
      repeat (9) tick();
      knight_x = 10'd100;
      knight_y = 10'd200;
      DrawX    = 10'd110;
      DrawY    = 10'd210;
      @(negedge vga_clk);
      check_cnt++;
      if (anim_state !== 2'd1 || frame_sel !== 3'd1 || sprite_hit !== 1'b1)
         $display("FAIL rstmid_pre: state/frame/hit %0d/%0d/%0d, want 1/1/1",
                  anim_state, frame_sel, sprite_hit);
      else pass_cnt++;
      #2;
      reset_n = 1'b0;
      #1;
      check_cnt++;
      if (anim_state !== 2'd0 || frame_sel !== 3'd0 || sprite_hit !== 1'b0 ||
          rom_address !== 12'd0)
         $display("FAIL rstmid_async: state/frame/hit/addr %0d/%0d/%0d/%0d, want 0/0/0/0",
                  anim_state, frame_sel, sprite_hit, rom_address);
      else pass_cnt++;
      @(negedge vga_clk);
      frame_tick = 1'b1;
      airborne   = 1'b1;
      @(negedge vga_clk);
      frame_tick = 1'b0;
      airborne   = 1'b0;
      check_cnt++;
      if (anim_state !== 2'd0 || frame_sel !== 3'd0 || sprite_hit !== 1'b0)
         $display("FAIL rstmid_tick: state/frame/hit %0d/%0d/%0d, want 0/0/0",
                  anim_state, frame_sel, sprite_hit);
      else pass_cnt++;
      reset_n = 1'b1;
      model_reset();
      @(negedge vga_clk);
      tick();
      check_cnt++;
      if (anim_state !== 2'd1 || frame_sel !== 3'd0)
         $display("FAIL rstmid_release: state/frame %0d/%0d, want 1/0", anim_state, frame_sel);
      else pass_cnt++;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n     = 1'b0;
      frame_tick  = 1'b0;
      airborne    = 1'b0;
      landed      = 1'b0;
      moving      = 1'b0;
      facing_left = 1'b0;
      knight_x    = 10'd0;
      knight_y    = 10'd0;
      DrawX       = 10'd0;
      DrawY       = 10'd0;
      model_reset();
      test_reset();
      test_walk();
      test_fall();
      test_land();
      test_addr_directed();
      test_random_addr();
      test_random_fsm();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
